// File: rtl/spram_rd_pkg.sv
// Shared types and default widths for the read-side controller of a 2048x40 single-port RAM bank.
package spram_rd_pkg;

    localparam int AWIDTH_DEF = 11;
    localparam int DWIDTH_DEF = 40;
    localparam int LWIDTH_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/spram_rd_fifo.sv
// Small first-word-fall-through FIFO holding RAM words plus their last-of-burst tag.
module spram_rd_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 41,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Entries are plain flops so reset leaves the head at zero.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                mem_q[gi] <= '0;
            end else if (push && (wr_ptr_q == PW'(gi))) begin
                mem_q[gi] <= push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/spram_burst_reader.sv
// Burst read controller: issues one RAM read per cycle under FIFO credit and streams words out
// on a valid/ready port with a last flag.
module spram_burst_reader
    import spram_rd_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int LWIDTH = LWIDTH_DEF,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AWIDTH-1:0] cmd_base,
    input  logic [LWIDTH-1:0] cmd_len,
    output logic [AWIDTH-1:0] mem_address,
    output logic              mem_wren,
    output logic [DWIDTH-1:0] mem_data,
    input  logic [DWIDTH-1:0] mem_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(DEPTH + 1);

    state_e            state_q;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH-1:0] mem_addr_q;
    logic [LWIDTH-1:0] rem_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              cmd_ready_q;
    logic              busy_q;
    logic              done_q;

    logic [CW-1:0]     fifo_count;
    logic [DWIDTH:0]   fifo_head;
    logic              fifo_pop;
    logic              issue;
    logic              drained;
    logic [31:0]       occupied;
    logic [31:0]       limit;

    assign fifo_pop = out_valid & out_ready;

    // An outstanding read already owns a FIFO slot; a pop this cycle frees one.
    assign occupied = 32'(fifo_count) + 32'(inflight_q);
    assign limit    = 32'(DEPTH) + 32'(fifo_pop);
    assign issue    = (state_q == ST_ISSUE) && (occupied < limit);

    // Finished once the final beat is leaving (or gone) and nothing is left in the RAM pipe.
    assign drained = !inflight_q &&
                     ((fifo_count == '0) || ((fifo_count == CW'(1)) && fifo_pop));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            mem_addr_q      <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            cmd_ready_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue && (rem_q == LWIDTH'(1));
            if (issue) begin
                mem_addr_q <= addr_q;
                addr_q     <= addr_q + AWIDTH'(1);
                rem_q      <= rem_q - LWIDTH'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        if (cmd_len == '0) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            addr_q  <= cmd_base;
                            rem_q   <= cmd_len;
                            busy_q  <= 1'b1;
                            state_q <= ST_ISSUE;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (issue && (rem_q == LWIDTH'(1))) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    spram_rd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DWIDTH + 1),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (inflight_q),
        .push_data ({inflight_last_q, mem_out}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign mem_address = issue ? addr_q : mem_addr_q;
    assign mem_wren    = 1'b0;
    assign mem_data    = '0;
    assign out_valid   = (fifo_count != '0);
    assign out_data    = fifo_head[DWIDTH-1:0];
    assign out_last    = fifo_head[DWIDTH] & out_valid;
    assign cmd_ready   = cmd_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_spram_burst_reader.sv
// Directed bench for spram_burst_reader with a behavioural 2048x40 RAM preloaded ram[i]=i.
module tb_spram_burst_reader;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [10:0] cmd_base;
    logic [11:0] cmd_len;
    logic [10:0] mem_address;
    logic        mem_wren;
    logic [39:0] mem_data;
    logic [39:0] mem_out;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [39:0] ram [2048];
    int n_cmp = 0;
    int n_err = 0;

    spram_burst_reader dut (
        .clk         (clk),
        .resetn      (resetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_base    (cmd_base),
        .cmd_len     (cmd_len),
        .mem_address (mem_address),
        .mem_wren    (mem_wren),
        .mem_data    (mem_data),
        .mem_out     (mem_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_out <= ram[mem_address];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one burst; bp selects the ready pattern 1,0,0 repeating, timed adds latency checks.
    task automatic burst(input int base, input int len, input bit bp, input bit timed);
        int idx, first_k, done_k, occ;
        bit got_done, prev_stall, prev_last;
        logic [39:0] prev_data;
        @(posedge clk); #1;
        for (int w = 0; w < 20 && !cmd_ready; w++) begin
            @(posedge clk); #1;
        end
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_base  = 11'(base);
        cmd_len   = 12'(len);
        out_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("accept_cmd_ready_low", cmd_ready, 0);
        chk("accept_busy", busy, 1);
        idx = 0; first_k = -1; done_k = -1; got_done = 0; prev_stall = 0;
        prev_last = 0; prev_data = '0;
        for (int k = 0; k < 3 * len + 20 && !got_done; k++) begin
            out_ready = bp ? ((k % 3) == 0) : 1'b1;
            @(negedge clk);
            chk("mem_write_zero", {mem_wren, mem_data}, 0);
            if (!bp && k < len) chk("mem_address", mem_address, (base + k) % 2048);
            if (prev_stall) chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
            if (bp) begin
                occ = int'(dut.u_fifo.count_q) + int'(dut.inflight_q);
                chk("occupancy_le_2", occ <= 2, 1);
            end
            if (out_valid && first_k < 0) first_k = k;
            if (out_valid && out_ready) begin
                chk("out_data", out_data, (base + idx) % 2048);
                chk("out_last", out_last, idx == len - 1);
                idx++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (done) begin
                got_done = 1;
                done_k   = k;
                chk("done_busy_low", busy, 0);
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("done_seen", got_done, 1);
        chk("word_count", idx, len);
        if (timed) begin
            chk("first_valid_cycle", first_k, 2);
            chk("done_cycle", done_k, len + 2);
        end
    endtask

    initial begin
        int got;
        for (int i = 0; i < 2048; i++) ram[i] = 40'(i);
        resetn = 1'b0; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_busy_done", {busy, done}, 0);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);

        burst(16, 4, 0, 1);
        burst(0, 8, 1, 0);
        burst(2046, 4, 0, 1);

        // Empty burst: done right after accept, then IDLE again.
        @(posedge clk); #1;
        for (int w = 0; w < 20 && !cmd_ready; w++) begin
            @(posedge clk); #1;
        end
        cmd_valid = 1'b1; cmd_base = 11'd7; cmd_len = 12'd0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("empty_done", {done, busy, out_valid, cmd_ready}, 4'b1000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("empty_after", {done, busy, out_valid, cmd_ready}, 4'b0001);

        // Full sweep immediately followed by another burst.
        burst(0, 2048, 0, 1);
        burst(5, 6, 0, 1);

        // Reset after 3 of 10 words.
        @(posedge clk); #1;
        for (int w = 0; w < 20 && !cmd_ready; w++) begin
            @(posedge clk); #1;
        end
        cmd_valid = 1'b1; cmd_base = 11'd100; cmd_len = 12'd10; out_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 30 && got < 3; k++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                chk("pre_rst_data", out_data, 100 + got);
                got++;
            end
            if (got < 3) begin
                @(posedge clk); #1;
            end
        end
        chk("pre_rst_words", got, 3);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_outputs", {out_valid, busy, cmd_ready, done}, 4'b0000);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_mid_rst", {out_valid, busy, cmd_ready}, 3'b001);
        burst(500, 3, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
